// File: rtl/mhsa_mon_pkg.sv
// Shared definitions for the MHSA interface monitor: FSM encoding and error-bit layout.
package mhsa_mon_pkg;

    localparam int ERR_W = 6;

    localparam int ERR_START_DROP  = 0;
    localparam int ERR_IBASE_CHG   = 1;
    localparam int ERR_OBASE_CHG   = 2;
    localparam int ERR_SOC_WR_BUSY = 3;
    localparam int ERR_TIMEOUT     = 4;
    localparam int ERR_SPUR_DONE   = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mon_state_e;

endpackage

// File: rtl/mhsa_if_monitor_if.sv
// Observed start/done handshake plus the base registers and SoC write port of the MHSA engine.
interface mhsa_if_monitor_if #(
    parameter int AW = 32
);
    logic          start;
    logic          done;
    logic [AW-1:0] input_base;
    logic [AW-1:0] output_base;
    logic          soc_write_en;
    logic [AW-1:0] soc_addr;

    modport master (
        output start, done, input_base, output_base, soc_write_en, soc_addr
    );

    modport slave (
        input start, done, input_base, output_base, soc_write_en, soc_addr
    );
endinterface

// File: rtl/mhsa_mon_errlog.sv
// Error logger: one register stage on the raw detections, then sticky bits, a pulse and
// first-error capture; clr wins over anything captured in the same cycle.
module mhsa_mon_errlog
    import mhsa_mon_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [ERR_W-1:0] det,
    input  logic [AW-1:0]    addr,
    output logic [ERR_W-1:0] err_sticky,
    output logic             err_pulse,
    output logic [ERR_W-1:0] first_err,
    output logic [AW-1:0]    first_addr
);

    logic [ERR_W-1:0] det_reg;
    logic [AW-1:0]    addr_reg;
    logic [ERR_W-1:0] sticky_bits;
    logic             pulse_reg;
    logic [ERR_W-1:0] first_err_reg;
    logic [AW-1:0]    first_addr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_reg  <= '0;
            addr_reg <= '0;
        end else if (clr) begin
            det_reg  <= '0;
            addr_reg <= '0;
        end else begin
            det_reg  <= det;
            addr_reg <= addr;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ERR_W; gi++) begin : g_sticky
            logic bit_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    bit_reg <= 1'b0;
                else if (clr)
                    bit_reg <= 1'b0;
                else if (det_reg[gi])
                    bit_reg <= 1'b1;
            end
            assign sticky_bits[gi] = bit_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_reg      <= 1'b0;
            first_err_reg  <= '0;
            first_addr_reg <= '0;
        end else if (clr) begin
            pulse_reg      <= 1'b0;
            first_err_reg  <= '0;
            first_addr_reg <= '0;
        end else begin
            pulse_reg <= |det_reg;
            // Only the very first error event since the last clear is recorded.
            if ((|det_reg) && (sticky_bits == '0)) begin
                first_err_reg  <= det_reg;
                first_addr_reg <= addr_reg;
            end
        end
    end

    assign err_sticky = sticky_bits;
    assign err_pulse  = pulse_reg;
    assign first_err  = first_err_reg;
    assign first_addr = first_addr_reg;

endmodule

// File: rtl/mhsa_if_monitor.sv
// Protocol monitor for the MHSA start/done interface: job FSM, cycle/job counters, error log.
// Optional timeout detection is built only when MHSA_IF_TIMEOUT_EN is defined.
module mhsa_if_monitor
    import mhsa_mon_pkg::*;
#(
    parameter int AW          = 32,
    parameter int CW          = 24,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    mhsa_if_monitor_if.slave  mon,
    output logic              busy,
    output logic [1:0]        state,
    output logic [CW-1:0]     run_cycles,
    output logic [CW-1:0]     job_count,
    output logic [ERR_W-1:0]  err_sticky,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  first_err,
    output logic [AW-1:0]     first_addr
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_BUSY = ST_BUSY;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]       state_reg, state_next;
    logic [AW-1:0]    ibase_reg, obase_reg;
    logic [CW-1:0]    run_cycles_reg, job_count_reg;
    logic             start_drop, launch, finish, in_busy, timeout_hit;
    logic [ERR_W-1:0] det;

    assign in_busy = (state_reg == S_BUSY);

    // done outranks a dropped start in BUSY, so a job ending with both is clean.
    always_comb begin
        state_next = state_reg;
        start_drop = 1'b0;
        case (state_reg)
            S_IDLE: if (mon.start && !mon.done) state_next = S_BUSY;
            S_BUSY: begin
                if (mon.done) begin
                    state_next = S_DONE;
                end else if (!mon.start) begin
                    state_next = S_IDLE;
                    start_drop = 1'b1;
                end
            end
            S_DONE: if (!mon.start) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign launch = (state_reg == S_IDLE) && (state_next == S_BUSY);
    assign finish = in_busy && mon.done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            ibase_reg      <= '0;
            obase_reg      <= '0;
            run_cycles_reg <= '0;
            job_count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (launch) begin
                ibase_reg <= mon.input_base;
                obase_reg <= mon.output_base;
            end
            if (clr) begin
                run_cycles_reg <= '0;
                job_count_reg  <= '0;
            end else begin
                if (launch)
                    run_cycles_reg <= '0;
                else if (in_busy && (run_cycles_reg != '1))
                    run_cycles_reg <= run_cycles_reg + 1'b1;
                if (finish)
                    job_count_reg <= job_count_reg + 1'b1;
            end
        end
    end

`ifdef MHSA_IF_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYC);
    logic to_fired_reg;

    // Armed per job so a saturated or held counter cannot re-flag the same job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_fired_reg <= 1'b0;
        else if (launch)
            to_fired_reg <= 1'b0;
        else if (timeout_hit)
            to_fired_reg <= 1'b1;
    end

    assign timeout_hit = in_busy && !to_fired_reg && (run_cycles_reg == TO_LIM);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        det                  = '0;
        det[ERR_START_DROP]  = start_drop;
        det[ERR_IBASE_CHG]   = in_busy && (mon.input_base != ibase_reg);
        det[ERR_OBASE_CHG]   = in_busy && (mon.output_base != obase_reg);
        det[ERR_SOC_WR_BUSY] = in_busy && mon.soc_write_en;
        det[ERR_TIMEOUT]     = timeout_hit;
        det[ERR_SPUR_DONE]   = (state_reg == S_IDLE) && mon.done;
    end

    mhsa_mon_errlog #(
        .AW(AW)
    ) u_errlog (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .det        (det),
        .addr       (mon.soc_addr),
        .err_sticky (err_sticky),
        .err_pulse  (err_pulse),
        .first_err  (first_err),
        .first_addr (first_addr)
    );

    assign busy       = in_busy;
    assign state      = state_reg;
    assign run_cycles = run_cycles_reg;
    assign job_count  = job_count_reg;

endmodule

// File: tb/tb_mhsa_if_monitor.sv
// Directed self-checking bench for mhsa_if_monitor (TIMEOUT_CYC=16; expectations follow MHSA_IF_TIMEOUT_EN).
module tb_mhsa_if_monitor;

    localparam int AW = 32;
    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          busy;
    logic [1:0]    state;
    logic [CW-1:0] run_cycles;
    logic [CW-1:0] job_count;
    logic [5:0]    err_sticky;
    logic          err_pulse;
    logic [5:0]    first_err;
    logic [AW-1:0] first_addr;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;

    mhsa_if_monitor_if #(.AW(AW)) bus ();

    mhsa_if_monitor #(
        .AW(AW), .CW(CW), .TIMEOUT_CYC(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .mon        (bus),
        .busy       (busy),
        .state      (state),
        .run_cycles (run_cycles),
        .job_count  (job_count),
        .err_sticky (err_sticky),
        .err_pulse  (err_pulse),
        .first_err  (first_err),
        .first_addr (first_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.done = 1'b0; bus.soc_write_en = 1'b0;
        bus.input_base = 32'h100; bus.output_base = 32'h200; bus.soc_addr = '0;

        // Reset state
        tick(2);
        check("rst_state", state, 0);
        check("rst_busy", busy, 0);
        check("rst_sticky", err_sticky, 0);
        check("rst_jobs", job_count, 0);
        rst_n = 1'b1;
        tick(1);

        // Clean job: start at cycle 0, done at 10, start drop at 11
        bus.start = 1'b1;
        tick(1);
        check("job_state_busy", state, 1);
        check("job_busy", busy, 1);
        check("job_run0", run_cycles, 0);
        tick(9);
        bus.done = 1'b1;
        tick(1);
        check("job_state_done", state, 2);
        check("job_count1", job_count, 1);
        check("job_run10", run_cycles, 10);
        bus.done = 1'b0; bus.start = 1'b0;
        tick(1);
        check("job_state_idle", state, 0);
        tick(2);
        check("job_sticky0", err_sticky, 0);
        check("job_run_hold", run_cycles, 10);

        // Start drop at BUSY cycle 3
        bus.start = 1'b1;
        tick(3);
        bus.start = 1'b0;
        tick(1);
        check("drop_state_idle", state, 0);
        check("drop_sticky_pre", err_sticky, 0);
        tick(1);
        check("drop_sticky", err_sticky, 6'b000001);
        check("drop_pulse", err_pulse, 1);
        check("drop_first", first_err, 6'b000001);
        check("drop_jobs", job_count, 1);
        tick(1);
        check("drop_pulse_end", err_pulse, 0);

        // Clear
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_sticky", err_sticky, 0);
        check("clr_jobs", job_count, 0);
        check("clr_run", run_cycles, 0);

        // Base change plus SoC write in the same BUSY cycle
        bus.start = 1'b1; bus.input_base = 32'h100;
        tick(1);
        bus.input_base = 32'h104; bus.soc_write_en = 1'b1; bus.soc_addr = 32'h40;
        tick(1);
        bus.input_base = 32'h100; bus.soc_write_en = 1'b0; bus.soc_addr = 32'h0;
        tick(1);
        check("base_sticky", err_sticky, 6'b001010);
        check("base_first", first_err, 6'b001010);
        check("base_addr", first_addr, 32'h40);
        check("base_pulse", err_pulse, 1);
        bus.done = 1'b1;
        tick(1);
        check("base_jobs", job_count, 1);
        bus.done = 1'b0; bus.start = 1'b0;
        tick(1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;

        // Timeout: no done for 20 BUSY cycles
        bus.start = 1'b1;
        tick(1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (err_pulse) pulses++;
        end
        check("to_busy", busy, 1);
`ifdef MHSA_IF_TIMEOUT_EN
        check("to_sticky", err_sticky, 6'b010000);
        check("to_pulses", pulses, 1);
`else
        check("to_sticky", err_sticky, 6'b000000);
        check("to_pulses", pulses, 0);
`endif
        bus.done = 1'b1;
        tick(1);
        bus.done = 1'b0; bus.start = 1'b0;
        tick(1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;

        // Spurious done, then clear together with another spurious done
        bus.done = 1'b1;
        tick(1);
        bus.done = 1'b0;
        tick(1);
        check("spur_sticky", err_sticky, 6'b100000);
        check("spur_first", first_err, 6'b100000);
        bus.done = 1'b1; clr = 1'b1;
        tick(1);
        bus.done = 1'b0; clr = 1'b0;
        check("spurclr_sticky", err_sticky, 0);
        check("spurclr_first", first_err, 0);
        tick(1);
        check("spurclr_sticky2", err_sticky, 0);

        // Mid-job asynchronous reset at BUSY cycle 5
        bus.start = 1'b1;
        tick(6);
        check("mid_run5", run_cycles, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_state", state, 0);
        check("mid_busy", busy, 0);
        check("mid_run", run_cycles, 0);
        check("mid_first_addr", first_addr, 0);
        #1;
        rst_n = 1'b1;
        tick(1);
        check("mid_restart", state, 1);
        tick(2);
        check("mid_sticky", err_sticky, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mhsa_if_monitor.md
MHSA_IF_MONITOR -- requirements
Module: mhsa_if_monitor

Interface
REQ-001 SHALL have parameter AW, default 32, width of input_base, output_base and soc_addr.
REQ-002 SHALL have parameter CW, default 24, width of the cycle and job counters.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 65536, the maximum number of BUSY cycles allowed before done.
REQ-004 SHALL have ports: clk input 1, the only clock; rst_n input 1, asynchronous active-low reset.
REQ-005 SHALL have inputs: start 1, done 1, input_base AW, output_base AW, soc_write_en 1, soc_addr AW, all observed only.
REQ-006 SHALL have input clr 1: synchronous clear of sticky errors and counters.
REQ-007 SHALL have outputs: busy 1, state 2, run_cycles CW, job_count CW.
REQ-008 SHALL have outputs: err_sticky 6, err_pulse 1, first_err 6, first_addr AW.

Function
REQ-009 SHALL implement FSM IDLE(0), BUSY(1), DONE(2), with state output equal to the encoding.
- IDLE->BUSY: start=1 and done=0.
- BUSY->DONE: done=1.
- DONE->IDLE: start=0.
- Otherwise the FSM holds its state.
REQ-010 SHALL capture input_base and output_base on the IDLE->BUSY edge.
REQ-011 SHALL assert busy=1 exactly while state==BUSY.
REQ-012 SHALL define error bits as follows:
- [0] START_DROP: start=0 in BUSY with done=0.
- [1] IBASE_CHG: input_base differs from its captured value in BUSY.
- [2] OBASE_CHG: output_base differs from its captured value in BUSY.
- [3] SOC_WR_BUSY: soc_write_en=1 in BUSY.
- [4] TIMEOUT.
- [5] SPURIOUS_DONE: done=1 in IDLE.
REQ-013 SHALL register all error detection, so err_sticky updates one cycle after the offending sample.
REQ-014 SHALL OR the new error bits into err_sticky; bits stay set until clr or reset.
REQ-015 SHALL pulse err_pulse for one cycle whenever any new error bit is detected, including bits already sticky.
REQ-016 SHALL load first_err with the detected bit vector, and first_addr with soc_addr, only when err_sticky was all-zero before that cycle; multiple simultaneous bits are all recorded.
REQ-017 SHALL, on START_DROP, move the FSM to IDLE; no job is counted.
REQ-018 SHALL increment run_cycles every BUSY cycle; it resets to 0 on each IDLE->BUSY edge and saturates at all-ones.
REQ-019 SHALL increment job_count on each BUSY->DONE transition, wrapping modulo 2^CW.
REQ-020 SHALL give done priority when done=1 and start=0 are sampled together in BUSY: BUSY->DONE, no START_DROP.
REQ-021 SHALL give clr priority over same-cycle error capture: sticky, first_err, first_addr and both counters go to 0, and the FSM state is unaffected.

Reset
REQ-022 SHALL, while rst_n=0, asynchronously force state=IDLE and zero all outputs, counters and captured bases.
REQ-023 SHALL, if reset is applied mid-job, bring the FSM up in IDLE with no error recorded; a start still high after release begins a new job.

Configuration
REQ-024 SHALL implement TIMEOUT detection only when MHSA_IF_TIMEOUT_EN is defined.
- With the macro: err bit 4 sets when run_cycles reaches TIMEOUT_CYC in BUSY, once per job, and the FSM stays in BUSY.
- Without the macro: bit 4 is tied to 0 and no comparator is built.

Structure
REQ-025 SHALL place the state enum, error-bit index constants and ERR_W=6 in shared package mhsa_mon_pkg.
REQ-026 SHALL use one sub-module, mhsa_mon_errlog, holding the sticky, pulse and first-error capture logic.

Verification
REQ-027 SHALL cover a clean job: start=1 at cycle 0, done=1 at cycle 10, start=0 at cycle 11 -> job_count=1, run_cycles=10, err_sticky=0.
REQ-028 SHALL cover a start drop: start=0 at BUSY cycle 3 -> err_sticky=6'b000001 and err_pulse one cycle later, state=IDLE, job_count unchanged.
REQ-029 SHALL cover base changes: input_base 0x100->0x104 plus soc_write_en=1 with soc_addr=0x40 in the same BUSY cycle -> first_err=6'b001010, first_addr=0x40.
REQ-030 SHALL cover a timeout with TIMEOUT_CYC=16 and the macro defined: no done for 20 cycles -> bit 4 set once, busy still 1; with the macro undefined -> bit 4 stays 0.
REQ-031 SHALL cover a spurious done then clear: done=1 in IDLE -> bit 5 set; then clr=1 together with another spurious done -> err_sticky=0 and first_err=0.
REQ-032 SHALL cover mid-job reset: rst_n=0 at BUSY cycle 5 -> all outputs 0 asynchronously, state=IDLE.
